// File: rtl/fb_write_scheduler_pkg.sv
// Shared framebuffer geometry and types for the GPU write path.
package gfx_pkg;

   localparam int FB_W      = 320;
   localparam int FB_H      = 240;
   localparam int FB_PIXELS = FB_W * FB_H;
   localparam int FB_ADDR_W = 17;

   typedef struct packed {
      logic [8:0] x;
      logic [7:0] y;
      logic [7:0] color;
   } fb_pix_t;

   typedef enum logic {
      CLEAR = 1'b0,
      DRAW  = 1'b1
   } fbw_state_e;

endpackage

// File: rtl/fb_write_scheduler_if.sv
// Rasterizer-to-scheduler pixel stream (valid/ready handshake).
interface fb_write_scheduler_if;

   logic       px_valid;
   logic       px_ready;
   logic [8:0] px_x;
   logic [7:0] px_y;
   logic [7:0] px_color;

   modport master (output px_valid, px_x, px_y, px_color, input px_ready);
   modport slave  (input px_valid, px_x, px_y, px_color, output px_ready);

endinterface

// File: rtl/fb_write_scheduler_vsync_edge_sync.sv
// Two-flop vsync synchronizer with a one-cycle falling-edge pulse.
module vsync_edge_sync (
   input  logic clk,
   input  logic rst,
   input  logic vsync,
   output logic swap_evt
);

   logic meta_q;
   logic sync_q;
   logic prev_q;

   always_ff @(posedge clk) begin
      if (!rst) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
         prev_q <= 1'b0;
      end else begin
         meta_q <= vsync;
         sync_q <= meta_q;
         prev_q <= sync_q;
      end
   end

   assign swap_evt = prev_q & ~sync_q;

endmodule

// File: rtl/fb_write_scheduler.sv
// Framebuffer write-port owner: clears the back buffer after each swap,
// then forwards on-screen rasterizer pixels as registered writes.
//
//   state | meaning
//   CLEAR | writing the latched clear colour to every address, ascending
//   DRAW  | accepting rasterizer pixels
module fb_write_scheduler
   import gfx_pkg::*;
#(
   parameter int ADDR_WIDTH = FB_ADDR_W,
   parameter int FB_WIDTH   = FB_W,
   parameter int FB_HEIGHT  = FB_H
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  vsync,
   input  logic                  clear_en,
   input  logic [7:0]            clear_color,
   fb_write_scheduler_if.slave   px,
   output logic                  frame_start,
   output logic                  clearing,
   output logic                  frame_overrun,
   output logic                  fb_wea,
   output logic [ADDR_WIDTH-1:0] fb_addra,
   output logic [7:0]            fb_dina
);

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(FB_WIDTH * FB_HEIGHT - 1);

   fbw_state_e            state, state_nxt;
   logic [ADDR_WIDTH-1:0] cnt, cnt_nxt;
   logic [7:0]            col_q, col_nxt, clr_col;
   logic                  swap_evt;
   logic                  overrun_nxt, fs_nxt, wea_nxt;
   logic [ADDR_WIDTH-1:0] addr_nxt, pix_addr;
   logic [7:0]            din_nxt;
   logic                  pix_on;
   fb_pix_t               pix;

   vsync_edge_sync u_vsync_edge_sync (
      .clk      (clk),
      .rst      (rst),
      .vsync    (vsync),
      .swap_evt (swap_evt)
   );

   assign pix      = '{x: px.px_x, y: px.px_y, color: px.px_color};
   assign pix_on   = (int'(pix.x) < FB_WIDTH) && (int'(pix.y) < FB_HEIGHT);
   assign pix_addr = ADDR_WIDTH'(pix.y) * ADDR_WIDTH'(FB_WIDTH) + ADDR_WIDTH'(pix.x);

   // The first clear write after reset sees the live colour so a clear
   // that starts out of reset still uses the configured value.
   assign clr_col     = (cnt == '0) ? clear_color : col_q;
   assign clearing    = (state == CLEAR);
   assign px.px_ready = (state == DRAW) && !swap_evt;

   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      col_nxt     = col_q;
      overrun_nxt = frame_overrun;
      wea_nxt     = 1'b0;
      addr_nxt    = fb_addra;
      din_nxt     = fb_dina;
      if (swap_evt) begin
         state_nxt = clear_en ? CLEAR : DRAW;
         cnt_nxt   = '0;
         col_nxt   = clear_color;
         if (state == CLEAR) overrun_nxt = 1'b1;
      end else begin
         case (state)
            CLEAR: begin
               wea_nxt  = 1'b1;
               addr_nxt = cnt;
               din_nxt  = clr_col;
               if (cnt == '0) col_nxt = clear_color;
               if (cnt == LAST_ADDR) begin
                  state_nxt = DRAW;
                  cnt_nxt   = '0;
               end else begin
                  cnt_nxt = cnt + 1'b1;
               end
            end
            DRAW: begin
               if (px.px_valid && pix_on) begin
                  wea_nxt  = 1'b1;
                  addr_nxt = pix_addr;
                  din_nxt  = pix.color;
               end
            end
            default: state_nxt = CLEAR;
         endcase
      end
      fs_nxt = (state_nxt == DRAW) && ((state == CLEAR) || swap_evt);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state         <= CLEAR;
         cnt           <= '0;
         col_q         <= '0;
         frame_overrun <= 1'b0;
         frame_start   <= 1'b0;
         fb_wea        <= 1'b0;
         fb_addra      <= '0;
         fb_dina       <= '0;
      end else begin
         state         <= state_nxt;
         cnt           <= cnt_nxt;
         col_q         <= col_nxt;
         frame_overrun <= overrun_nxt;
         frame_start   <= fs_nxt;
         fb_wea        <= wea_nxt;
         fb_addra      <= addr_nxt;
         fb_dina       <= din_nxt;
      end
   end

endmodule

// File: tb/tb_fb_write_scheduler.sv
// Directed and randomized checks of fb_write_scheduler on a reduced 40x12 framebuffer.
module tb_fb_write_scheduler;
   import gfx_pkg::*;

   localparam int W  = 40;
   localparam int H  = 12;
   localparam int N  = W * H;
   localparam int AW = 17;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          vsync = 1'b1;
   logic          clear_en = 1'b1;
   logic [7:0]    clear_color = 8'h00;
   logic          frame_start, clearing, frame_overrun, fb_wea;
   logic [AW-1:0] fb_addra;
   logic [7:0]    fb_dina;

   int n_tests = 0;
   int n_fail  = 0;

   fb_write_scheduler_if pif ();

   fb_write_scheduler #(.ADDR_WIDTH(AW), .FB_WIDTH(W), .FB_HEIGHT(H)) dut (
      .clk           (clk),
      .rst           (rst),
      .vsync         (vsync),
      .clear_en      (clear_en),
      .clear_color   (clear_color),
      .px            (pif),
      .frame_start   (frame_start),
      .clearing      (clearing),
      .frame_overrun (frame_overrun),
      .fb_wea        (fb_wea),
      .fb_addra      (fb_addra),
      .fb_dina       (fb_dina)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   // Watch a whole clear from the current sample: every address exactly once,
   // ascending, in the given colour, followed by a single frame_start.
   task automatic observe_clear(input logic [7:0] col, input string tag);
      int wr, bad, fs, clr;
      wr = 0; bad = 0; fs = 0; clr = 0;
      for (int i = 0; i < N + 20; i++) begin
         if (clearing === 1'b1) clr++;
         if (fb_wea === 1'b1) begin
            if (fb_addra !== AW'(wr) || fb_dina !== col) bad++;
            wr++;
         end
         if (frame_start === 1'b1) fs++;
         @(negedge clk);
      end
      chk({tag, "_clear_cycles"}, 32'(clr), 32'(N));
      chk({tag, "_clear_writes"}, 32'(wr), 32'(N));
      chk({tag, "_clear_bad"}, 32'(bad), 32'd0);
      chk({tag, "_frame_start_cnt"}, 32'(fs), 32'd1);
      chk1({tag, "_ready_after"}, pif.px_ready, 1'b1);
   endtask

   initial begin
      int found, bad, wr, fs;
      int x, y;
      logic       exp_wr;
      int         exp_addr;
      logic [7:0] exp_col;

      pif.px_valid = 1'b0;
      pif.px_x     = '0;
      pif.px_y     = '0;
      pif.px_color = '0;

      // reset state
      repeat (3) @(negedge clk);
      chk1("rst_wea", fb_wea, 1'b0);
      chk("rst_addra", 32'(fb_addra), 32'd0);
      chk("rst_dina", 32'(fb_dina), 32'd0);
      chk1("rst_frame_start", frame_start, 1'b0);
      chk1("rst_overrun", frame_overrun, 1'b0);
      chk1("rst_ready", pif.px_ready, 1'b0);
      chk1("rst_clearing", clearing, 1'b1);

      // clear out of reset
      clear_color = 8'h1C;
      rst = 1'b1;
      observe_clear(8'h1C, "boot");
      chk1("boot_overrun", frame_overrun, 1'b0);

      // single pixel
      pif.px_valid = 1'b1; pif.px_x = 9'd5; pif.px_y = 8'd2; pif.px_color = 8'hE0;
      chk1("px1_ready", pif.px_ready, 1'b1);
      @(negedge clk);
      pif.px_valid = 1'b0;
      chk1("px1_wea", fb_wea, 1'b1);
      chk("px1_addr", 32'(fb_addra), 32'(2 * W + 5));
      chk("px1_data", 32'(fb_dina), 32'hE0);

      // last on-screen pixel then off-screen, back to back
      pif.px_valid = 1'b1; pif.px_x = 9'(W - 1); pif.px_y = 8'(H - 1); pif.px_color = 8'h3C;
      @(negedge clk);
      chk1("last_wea", fb_wea, 1'b1);
      chk("last_addr", 32'(fb_addra), 32'(N - 1));
      chk1("offscr_ready", pif.px_ready, 1'b1);
      pif.px_x = 9'(W); pif.px_y = 8'd0; pif.px_color = 8'h99;
      @(negedge clk);
      pif.px_valid = 1'b0;
      chk1("offscr_wea", fb_wea, 1'b0);

      // randomized pixel stream against the address/visibility rule
      bad = 0; wr = 0; exp_wr = 1'b0; exp_addr = 0; exp_col = 8'h00;
      for (int i = 0; i <= 300; i++) begin
         if (i > 0) begin
            if (fb_wea !== exp_wr) bad++;
            else if (exp_wr && (int'(fb_addra) != exp_addr || fb_dina !== exp_col)) bad++;
            if (fb_wea === 1'b1) wr++;
            if (pif.px_ready !== 1'b1) bad++;
         end
         if (i == 300) break;
         x = int'($urandom_range(0, W + 7));
         y = int'($urandom_range(0, H + 3));
         pif.px_valid = ($urandom_range(0, 3) != 0);
         pif.px_x     = 9'(x);
         pif.px_y     = 8'(y);
         pif.px_color = 8'($urandom);
         exp_wr   = pif.px_valid && x < W && y < H;
         exp_addr = y * W + x;
         exp_col  = pif.px_color;
         @(negedge clk);
      end
      pif.px_valid = 1'b0;
      chk("rand_px_bad", 32'(bad), 32'd0);
      n_tests++;
      assert (wr > 100) else begin
         n_fail++;
         $error("FAIL rand_px_writes observed=%0d required>100", wr);
      end
      @(negedge clk);

      // swap during DRAW with a pixel pending
      clear_color = 8'h5A;
      pif.px_valid = 1'b1; pif.px_x = 9'd3; pif.px_y = 8'd1; pif.px_color = 8'h77;
      vsync = 1'b0;
      found = 0;
      for (int i = 0; i < 8 && found == 0; i++) begin
         @(negedge clk);
         if (pif.px_ready === 1'b0) found = 1;
      end
      chk("swap_draw_seen", 32'(found), 32'd1);
      chk1("swap_draw_clearing", clearing, 1'b0);
      chk1("swap_prev_write", fb_wea, 1'b1);
      chk("swap_prev_addr", 32'(fb_addra), 32'(1 * W + 3));
      @(negedge clk);
      pif.px_valid = 1'b0;
      vsync = 1'b1;
      chk1("swap_draw_into_clear", clearing, 1'b1);
      chk1("swap_draw_no_accept", fb_wea, 1'b0);
      observe_clear(8'h5A, "swap_draw");
      chk1("swap_draw_overrun", frame_overrun, 1'b0);

      // swap arriving mid-clear
      clear_color = 8'hC3;
      vsync = 1'b0;
      found = 0;
      for (int i = 0; i < 8 && found == 0; i++) begin
         @(negedge clk);
         if (clearing === 1'b1) found = 1;
      end
      chk("ovr_clear_started", 32'(found), 32'd1);
      repeat (100) @(negedge clk);
      chk1("ovr_before", frame_overrun, 1'b0);
      vsync = 1'b1;
      repeat (4) @(negedge clk);
      vsync = 1'b0;
      found = 0;
      for (int i = 0; i < 8 && found == 0; i++) begin
         @(negedge clk);
         if (frame_overrun === 1'b1) found = 1;
      end
      chk("ovr_set", 32'(found), 32'd1);
      chk1("ovr_clearing", clearing, 1'b1);
      observe_clear(8'hC3, "overrun");
      chk1("ovr_sticky", frame_overrun, 1'b1);

      // swap with clear disabled
      vsync = 1'b1;
      repeat (4) @(negedge clk);
      clear_en = 1'b0;
      vsync = 1'b0;
      found = 0;
      for (int i = 0; i < 8 && found == 0; i++) begin
         @(negedge clk);
         if (pif.px_ready === 1'b0) found = 1;
      end
      chk("noclr_swap_seen", 32'(found), 32'd1);
      @(negedge clk);
      chk1("noclr_clearing", clearing, 1'b0);
      chk1("noclr_frame_start", frame_start, 1'b1);
      chk1("noclr_ready", pif.px_ready, 1'b1);
      wr = 0; fs = 0;
      for (int i = 0; i < 10; i++) begin
         if (fb_wea === 1'b1) wr++;
         @(negedge clk);
         if (frame_start === 1'b1) fs++;
      end
      chk("noclr_writes", 32'(wr), 32'd0);
      chk("noclr_extra_fs", 32'(fs), 32'd0);
      clear_en = 1'b1;

      // reset mid-clear
      vsync = 1'b1;
      repeat (4) @(negedge clk);
      vsync = 1'b0;
      found = 0;
      for (int i = 0; i < 8 && found == 0; i++) begin
         @(negedge clk);
         if (clearing === 1'b1) found = 1;
      end
      chk("rst2_clear_started", 32'(found), 32'd1);
      repeat (50) @(negedge clk);
      chk1("rst2_mid_clear_wea", fb_wea, 1'b1);
      rst = 1'b0;
      @(negedge clk);
      chk1("rst2_wea", fb_wea, 1'b0);
      chk("rst2_addra", 32'(fb_addra), 32'd0);
      chk("rst2_dina", 32'(fb_dina), 32'd0);
      chk1("rst2_frame_start", frame_start, 1'b0);
      chk1("rst2_overrun", frame_overrun, 1'b0);
      chk1("rst2_ready", pif.px_ready, 1'b0);
      repeat (3) @(negedge clk);
      chk1("rst2_hold_wea", fb_wea, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
